pc_adder_arbiter: RTL
=====================

# pc_adder_arbiter

Shares one WIDTH-bit word-address ripple adder between two requesters, e.g. the PC incrementer and the branch-target unit. Each requester presents an operand pair with a request/grant handshake. The arbiter picks one per cycle with round-robin priority and feeds it through the adder. The registered sum, carry-out and requester ID are returned through a one-entry output buffer with valid/ready backpressure.

## Interface
- WIDTH, 30, operand/sum width; operands are word addresses (byte address bits 31:2).
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- req0  in  1  requester 0 has a valid operand pair.
- a0, b0  in  WIDTH each  requester 0 operands.
- gnt0  out  1  requester 0 transfer accepted this cycle (combinational).
- req1  in  1  requester 1 has a valid operand pair.
- a1, b1  in  WIDTH each  requester 1 operands.
- gnt1  out  1  requester 1 transfer accepted this cycle (combinational).
- out_valid  out  1  output buffer holds a result.
- out_ready  in  1  consumer accepts the result this cycle.
- out_id  out  1  requester that produced the buffered result.
- out_sum  out  WIDTH  (a + b) mod 2^WIDTH.
- out_cout  out  1  carry out of bit WIDTH-1.

## Operation
- One combinational WIDTH-bit adder is instantiated internally, with carry-in tied to 0. Its inputs are multiplexed from the granted requester. The result is never computed for an ungranted requester.
- Output buffer state machine:
  - EMPTY (out_valid=0) moves to FULL on any grant.
  - FULL stays FULL when (out_ready and grant); a new result replaces the old one in the same edge.
  - FULL moves to EMPTY when (out_ready and no grant).
  - FULL holds when out_ready=0.
- slot_free = !out_valid || out_ready.
- Grants are issued only when slot_free=1 and reset=0. At most one of gnt0/gnt1 is high in any cycle.
- Round-robin arbitration uses register last_id:
  - Only one requester asserting: it is granted.
  - Both asserting: grant goes to the requester != last_id.
  - last_id updates to the granted ID on every grant and holds otherwise.
- Transfer occurs at the edge where req_i && gnt_i. At that edge out_sum, out_cout and out_id load from the adder and the selected ID.
- Requesters must hold req_i, a_i and b_i stable until gnt_i is seen. The arbiter does not latch operands before the grant.
- Arithmetic: sum wraps mod 2^WIDTH and out_cout reports the wrap. No sign or overflow interpretation.
- Reset values: out_valid=0, out_id=0, out_sum=0, out_cout=0, last_id=1 (requester 0 wins the first contention). gnt0=gnt1=0 while reset=1, regardless of req.
- Reset mid-operation: a buffered result is discarded and a pending request is not granted. After reset deasserts, requesters re-present operands as normal.

## Timing
- Latency: 1 cycle. A grant at edge N gives out_valid=1 with the result, visible after edge N.
- Throughput: 1 result/cycle when out_ready stays high.
- gnt_i depends combinationally on req0, req1, out_valid, out_ready, last_id and reset. No combinational path from a_i/b_i to any grant.
- Backpressure: when out_valid=1 and out_ready=0, both grants are 0 and the outputs hold stable until accepted.
- Simultaneous consume and produce in FULL: the old result is consumed and the new one is loaded at the same edge, so there is no bubble.
- No internal timeout and no starvation. Under continuous contention, grants strictly alternate 0,1,0,1...

## Test plan
- Single request: reset then release; req0=1, a0=0x0000_0010, b0=0x0000_0001, out_ready=1. Expect gnt0=1 in the same cycle; next cycle out_valid=1, out_id=0, out_sum=0x11, out_cout=0.
- Wrap-around: req1 with a1=0x3FFF_FFFF, b1=0x0000_0001, WIDTH=30. Expect out_sum=0, out_cout=1, out_id=1.
- Contention fairness: req0=req1=1 held for 6 cycles with out_ready=1. Expect grant sequence 0,1,0,1,0,1 and out_id following it one cycle later.
- Backpressure: fill the buffer, then hold out_ready=0 for 3 cycles with req0=1. Expect gnt0=0 and out_sum/out_id unchanged for those cycles. Raise out_ready: gnt0=1 in that cycle and the new result appears next cycle with no bubble.
- Reset mid-operation: with out_valid=1 and req1 pending, assert reset for 1 cycle. Expect gnt0=gnt1=0 during reset and out_valid=0, out_sum=0, out_id=0 after it. On the first contention after reset, requester 0 is granted.

Source files
------------

// File: rtl/pc_adder_arbiter.sv
// pc_adder_arbiter: two requesters share one word-address ripple adder.
// A round-robin arbiter grants one operand pair per cycle. The registered
// sum, carry-out and requester ID sit in a one-entry output buffer that the
// consumer drains with valid/ready.
//
// Handshake rules:
//   - Requester side: a transfer happens at the rising edge where reqN_i and
//     gntN_o are both high. A requester keeps reqN_i, aN_i and bN_i stable
//     until it sees its grant. Operands are not latched before the grant.
//   - Consumer side: a result is consumed at the rising edge where out_valid_o
//     and out_ready_i are both high. While out_valid_o=1 and out_ready_i=0 the
//     buffered result stays stable and no grant is issued.
module pc_adder_arbiter #(
   parameter int WIDTH = 30
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             req0_i,
   input  logic [WIDTH-1:0] a0_i,
   input  logic [WIDTH-1:0] b0_i,
   output logic             gnt0_o,
   input  logic             req1_i,
   input  logic [WIDTH-1:0] a1_i,
   input  logic [WIDTH-1:0] b1_i,
   output logic             gnt1_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic             out_id_o,
   output logic [WIDTH-1:0] out_sum_o,
   output logic             out_cout_o,
   output logic             state_o
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } buf_state_e;

   buf_state_e       state_q;
   logic             last_id_q;
   logic             out_id_q;
   logic [WIDTH-1:0] out_sum_q;
   logic             out_cout_q;

   logic             slot_free;
   logic             pick1;
   logic             gnt0_d;
   logic             gnt1_d;
   logic             any_gnt;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] sum_d;
   logic             cout_d;

   // Round-robin grant: requester 1 wins when alone, or in contention when
   // requester 0 was served last. Nothing is granted in reset or when the
   // buffer cannot take a new result this edge.
   always_comb begin
      slot_free = (state_q == EMPTY) || out_ready_i;
      pick1     = req1_i && (!req0_i || (last_id_q == 1'b0));
      gnt1_d    = !reset_i && slot_free && pick1;
      gnt0_d    = !reset_i && slot_free && req0_i && !pick1;
      any_gnt   = gnt0_d || gnt1_d;
   end

   // Operand mux: only the granted requester reaches the adder.
   always_comb begin
      op_a = '0;
      op_b = '0;
      if (gnt1_d) begin
         op_a = a1_i;
         op_b = b1_i;
      end else if (gnt0_d) begin
         op_a = a0_i;
         op_b = b0_i;
      end
   end

   // Ripple-carry adder, carry-in tied to 0; the final carry is the wrap flag.
   always_comb begin : ripple_adder
      logic c;
      c     = 1'b0;
      sum_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         sum_d[i] = op_a[i] ^ op_b[i] ^ c;
         c        = (op_a[i] & op_b[i]) | (op_a[i] & c) | (op_b[i] & c);
      end
      cout_d = c;
   end

   // Output buffer FSM plus arbitration history. A grant always loads the
   // buffer, even in FULL with out_ready_i high, so back-to-back results
   // flow with no bubble.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= EMPTY;
         last_id_q  <= 1'b1;
         out_id_q   <= 1'b0;
         out_sum_q  <= '0;
         out_cout_q <= 1'b0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (any_gnt) begin
                  state_q <= FULL;
               end
            end
            FULL: begin
               if (any_gnt) begin
                  state_q <= FULL;
               end else if (out_ready_i) begin
                  state_q <= EMPTY;
               end
            end
            default: state_q <= EMPTY;
         endcase
         if (any_gnt) begin
            last_id_q  <= gnt1_d;
            out_id_q   <= gnt1_d;
            out_sum_q  <= sum_d;
            out_cout_q <= cout_d;
         end
      end
   end

   assign gnt0_o      = gnt0_d;
   assign gnt1_o      = gnt1_d;
   assign out_valid_o = (state_q == FULL);
   assign out_id_o    = out_id_q;
   assign out_sum_o   = out_sum_q;
   assign out_cout_o  = out_cout_q;
   assign state_o     = state_q;

endmodule
